// File: rtl/traffic_phase_controller.sv
// Timed, demand-driven phase controller for a main/side-road intersection with a shared walk phase.
// Define TLC_PREEMPT_EN to add the emergency Preempt input and the all-red HOLD state.
module traffic_phase_controller #(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 8,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 3,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       LightCLK,
    input  logic       Reset_n,
    input  logic       Tick,
    input  logic       Sensor34,
    input  logic       WalkReq,
`ifdef TLC_PREEMPT_EN
    input  logic       Preempt,
`endif
    output logic [2:0] Lane12,
    output logic [2:0] Lane34,
    output logic       Walk,
    output logic [2:0] Phase
);

    typedef enum logic [2:0] {
        s_g12  = 3'd0,
        s_y12  = 3'd1,
        s_r12  = 3'd2,
        s_g34  = 3'd3,
        s_y34  = 3'd4,
        s_r34  = 3'd5,
        s_walk = 3'd6
`ifdef TLC_PREEMPT_EN
        , s_hold = 3'd7
`endif
    } state_t;

    localparam logic [2:0] lamp_red    = 3'b100;
    localparam logic [2:0] lamp_yellow = 3'b010;
    localparam logic [2:0] lamp_green  = 3'b001;

    // Terminal counts: a phase ends on the tick where cnt reaches duration-1
    localparam logic [CNT_W-1:0] green_min_last = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] green_max_last = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] yellow_last    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] allred_last    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] walk_last      = CNT_W'(WALK_T - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             walk_pend_q, walk_pend_d;
    logic             target_q, target_d;   // 1: leave WALK into G34, 0: into G12
    logic [2:0]       lane12_c, lane34_c;
    logic             walk_c;

    // Next-state, counter, walk-pending and target logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        walk_pend_d = walk_pend_q | WalkReq;

        if (Tick) begin
            case (state_q)
                s_g12: begin
                    if (cnt_q == green_max_last && (Sensor34 || walk_pend_q)) begin
                        state_d = s_y12;
                    end
                end
                s_y12: begin
                    if (cnt_q == yellow_last) state_d = s_r12;
                end
                s_r12: begin
                    if (cnt_q == allred_last) begin
                        if (walk_pend_q) begin
                            state_d  = s_walk;
                            target_d = 1'b1;
                        end else begin
                            state_d = s_g34;
                        end
                    end
                end
                s_g34: begin
                    if ((cnt_q >= green_min_last && (!Sensor34 || walk_pend_q)) ||
                        cnt_q == green_max_last) begin
                        state_d = s_y34;
                    end
                end
                s_y34: begin
                    if (cnt_q == yellow_last) state_d = s_r34;
                end
                s_r34: begin
                    if (cnt_q == allred_last) begin
                        if (walk_pend_q) begin
                            state_d  = s_walk;
                            target_d = 1'b0;
                        end else begin
                            state_d = s_g12;
                        end
                    end
                end
                s_walk: begin
                    if (cnt_q == walk_last) state_d = target_q ? s_g34 : s_g12;
                end
                default: state_d = state_q;
            endcase
        end

`ifdef TLC_PREEMPT_EN
        // Preemption overrides normal sequencing; yellow and all-red still time out on Tick
        if (Preempt) begin
            case (state_q)
                s_g12:  state_d = s_y12;
                s_g34:  state_d = s_y34;
                s_walk: state_d = s_hold;
                s_r12, s_r34: begin
                    if (Tick && cnt_q == allred_last) state_d = s_hold;
                end
                s_hold: state_d = s_hold;
                default: state_d = state_d;
            endcase
        end else if (state_q == s_hold) begin
            state_d = s_g12;
        end
`endif

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (Tick) begin
            if (!(state_q == s_g12 && cnt_q == green_max_last)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Entering WALK serves the request; clear beats a same-cycle set
        if (state_d == s_walk && state_q != s_walk) begin
            walk_pend_d = 1'b0;
        end
    end

    // Signal-head decode of the upcoming state, registered alongside it
    always_comb begin
        lane12_c = lamp_red;
        lane34_c = lamp_red;
        walk_c   = 1'b0;
        case (state_d)
            s_g12:   lane12_c = lamp_green;
            s_y12:   lane12_c = lamp_yellow;
            s_g34:   lane34_c = lamp_green;
            s_y34:   lane34_c = lamp_yellow;
            s_walk:  walk_c   = 1'b1;
            default: walk_c   = 1'b0;
        endcase
    end

    always_ff @(posedge LightCLK) begin
        if (!Reset_n) begin
            state_q     <= s_g12;
            cnt_q       <= '0;
            walk_pend_q <= 1'b0;
            target_q    <= 1'b1;
            Lane12      <= lamp_green;
            Lane34      <= lamp_red;
            Walk        <= 1'b0;
            Phase       <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            walk_pend_q <= walk_pend_d;
            target_q    <= target_d;
            Lane12      <= lane12_c;
            Lane34      <= lane34_c;
            Walk        <= walk_c;
            Phase       <= state_d;
        end
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: phase-level reference model checked every cycle,
// plus directed scenarios with hand-computed phase pins.
module tb_traffic_phase_controller;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 3;

    logic       LightCLK = 1'b0;
    logic       Reset_n  = 1'b0;
    logic       Tick     = 1'b1;
    logic       Sensor34 = 1'b0;
    logic       WalkReq  = 1'b0;
    logic [2:0] Lane12, Lane34, Phase;
    logic       Walk;

    int checks   = 0;
    int failures = 0;

    traffic_phase_controller dut (
        .LightCLK (LightCLK),
        .Reset_n  (Reset_n),
        .Tick     (Tick),
        .Sensor34 (Sensor34),
        .WalkReq  (WalkReq),
`ifdef TLC_PREEMPT_EN
        .Preempt  (1'b0),
`endif
        .Lane12   (Lane12),
        .Lane34   (Lane34),
        .Walk     (Walk),
        .Phase    (Phase)
    );

    always #5 LightCLK = ~LightCLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Phase table: 0 G12, 1 Y12, 2 R12, 3 G34, 4 Y34, 5 R34, 6 WALK
    function automatic int dur(input int p);
        case (p)
            0, 3:    return GREEN_MAX;
            1, 4:    return YELLOW_T;
            2, 5:    return ALLRED_T;
            default: return WALK_T;
        endcase
    endfunction

    function automatic int lamp12(input int p);
        return (p == 0) ? 1 : (p == 1) ? 2 : 4;
    endfunction

    function automatic int lamp34(input int p);
        return (p == 3) ? 1 : (p == 4) ? 2 : 4;
    endfunction

    // Reference model: phase, ticks spent in it, pending walk, phase to follow WALK
    bit m_valid = 1'b0;
    int m_phase, m_age, m_tgt, m_nxt;
    bit m_pend, m_done;

    always @(posedge LightCLK) begin
        if (!Reset_n) begin
            m_phase = 0;
            m_age   = 0;
            m_pend  = 1'b0;
            m_tgt   = 3;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_nxt  = m_phase;
            m_done = (m_age + 1 >= dur(m_phase));
            if (Tick) begin
                case (m_phase)
                    0: if (m_done && (Sensor34 || m_pend)) m_nxt = 1;
                    1: if (m_done) m_nxt = 2;
                    2: if (m_done) begin
                           if (m_pend) begin m_nxt = 6; m_tgt = 3; end
                           else m_nxt = 3;
                       end
                    3: if (m_done || (m_age + 1 >= GREEN_MIN && (!Sensor34 || m_pend))) m_nxt = 4;
                    4: if (m_done) m_nxt = 5;
                    5: if (m_done) begin
                           if (m_pend) begin m_nxt = 6; m_tgt = 0; end
                           else m_nxt = 0;
                       end
                    default: if (m_done) m_nxt = m_tgt;
                endcase
            end
            if (m_nxt == 6 && m_phase != 6) m_pend = 1'b0;
            else m_pend = m_pend | WalkReq;
            if (m_nxt != m_phase) m_age = 0;
            else if (Tick && !(m_phase == 0 && m_done)) m_age++;
            m_phase = m_nxt;
        end
    end

    // Every-cycle comparison against the model, plus the lane-conflict invariant
    always @(negedge LightCLK) begin
        if (m_valid) begin
            check("phase", int'(Phase), m_phase);
            check("lane12", int'(Lane12), lamp12(m_phase));
            check("lane34", int'(Lane34), lamp34(m_phase));
            check("walk", int'(Walk), int'(m_phase == 6));
            check("no_conflict", int'(Lane12 == 3'b100 || Lane34 == 3'b100), 1);
        end
    end

    task automatic step();
        @(posedge LightCLK);
        #1;
    endtask

    task automatic stepn(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        check("rst_phase", int'(Phase), 0);
        check("rst_lane12", int'(Lane12), 1);
        check("rst_lane34", int'(Lane34), 4);
        check("rst_walk", int'(Walk), 0);
    endtask

    initial begin
        // No demand: G12 rests
        Tick = 1'b1;
        do_reset();
        stepn(30);
        check("idle_phase", int'(Phase), 0);
        check("idle_lane12", int'(Lane12), 1);

        // Sensor34 held: full cycle with G34 capped at GREEN_MAX
        Sensor34 = 1'b1;
        do_reset();
        stepn(7);  check("s2_g12_last", int'(Phase), 0);
        step();    check("s2_y12", int'(Phase), 1);
        stepn(2);  check("s2_r12", int'(Phase), 2);
        step();    check("s2_g34", int'(Phase), 3);
        stepn(7);  check("s2_g34_cap", int'(Phase), 3);
        step();    check("s2_y34", int'(Phase), 4);
        stepn(2);  check("s2_r34", int'(Phase), 5);
        step();    check("s2_back_g12", int'(Phase), 0);

        // Sensor34 drops during G34: leave after GREEN_MIN
        Sensor34 = 1'b1;
        do_reset();
        stepn(12);
        Sensor34 = 1'b0;
        stepn(2);  check("s3_g34_min", int'(Phase), 3);
        step();    check("s3_y34", int'(Phase), 4);

        // Walk request, then a second request during WALK
        Sensor34 = 1'b0;
        do_reset();
        stepn(2);
        WalkReq = 1'b1; step(); WalkReq = 1'b0;
        stepn(7);  check("s4_r12", int'(Phase), 2);
        step();    check("s4_walk", int'(Phase), 6);
                   check("s4_walk_lamp", int'(Walk), 1);
                   check("s4_walk_l12", int'(Lane12), 4);
                   check("s4_walk_l34", int'(Lane34), 4);
        WalkReq = 1'b1; step(); WalkReq = 1'b0;
        step();    check("s4_walk3", int'(Phase), 6);
        step();    check("s4_g34", int'(Phase), 3);
                   check("s4_walk_off", int'(Walk), 0);
        stepn(3);  check("s4_g34_min", int'(Phase), 3);
        step();    check("s4_y34", int'(Phase), 4);
        stepn(2);  check("s4_r34", int'(Phase), 5);
        step();    check("s4_walk2", int'(Phase), 6);
        stepn(2);  check("s4_walk2_end", int'(Phase), 6);
        step();    check("s4_g12", int'(Phase), 0);

        // Tick every 4th cycle, reset mid-Y34
        Sensor34 = 1'b1;
        do_reset();
        for (int i = 1; i <= 77; i++) begin
            Tick = (i % 4 == 0);
            step();
            if (i == 31) check("s5_g12_late", int'(Phase), 0);
            if (i == 32) check("s5_y12", int'(Phase), 1);
            if (i == 75) check("s5_g34_late", int'(Phase), 3);
            if (i == 76) check("s5_y34", int'(Phase), 4);
        end
        check("s5_mid_y34", int'(Phase), 4);
        Tick = 1'b0;
        do_reset();
        for (int i = 79; i <= 100; i++) begin
            Tick = (i % 4 == 0);
            step();
        end
        check("s5_after_rst", int'(Phase), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
